// File: rtl/mipsfpga_ahb_interconnect_pkg.sv
// Shared AHB-lite constants and default-slave state encoding
// for the MIPSfpga single-master interconnect.
package mipsfpga_ahb_interconnect_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_e;

   // NONSEQ/SEQ carry a real transfer; IDLE/BUSY do not
   function automatic logic trans_active(input logic [1:0] t);
      logic act;
      act = 1'b0;
      unique case (t)
         HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
         HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
         default:                   act = 1'b0;
      endcase
      return act;
   endfunction

endpackage

// File: rtl/mipsfpga_ahb_interconnect_default_slave.sv
// Built-in default slave: two-cycle ERROR for unmapped transfers.
// With BUS_TIMEOUT_EN it also forces ERROR on a stalled slave.
module mipsfpga_ahb_interconnect_default_slave
   import mipsfpga_ahb_interconnect_pkg::*;
#(
   parameter int TIMEOUT_CYC = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic stall,
   output logic busy,
   output logic hready,
   output logic hresp,
   output logic timeout_p
);

   ds_state_e state_q, state_d;
   logic      busy_q, busy_d;
   logic      hready_q, hready_d;
   logic      hresp_q, hresp_d;
   logic      tmo_p_q, tmo_p_d;
   logic      tmo;

`ifdef BUS_TIMEOUT_EN
   localparam logic [15:0] TMO_MAX = 16'(TIMEOUT_CYC - 1);

   logic [15:0] timer_q, timer_d;

   // count stalled slave cycles, saturating at the limit
   always_comb begin
      timer_d = 16'd0;
      tmo     = 1'b0;
      if (stall && (state_q == DS_IDLE)) begin
         tmo = (timer_q == TMO_MAX);
         if (timer_q != TMO_MAX)
            timer_d = timer_q + 16'd1;
         else
            timer_d = timer_q;
      end
   end

   // stall timer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         timer_q <= 16'd0;
      else
         timer_q <= timer_d;
   end
`else
   logic unused_tmo;

   assign tmo        = 1'b0;
   assign unused_tmo = stall ^ (TIMEOUT_CYC > 0);
`endif

   // next state and registered response outputs
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DS_IDLE: if (start || tmo) state_d = DS_ERR1;
         DS_ERR1: state_d = DS_ERR2;
         DS_ERR2: state_d = start ? DS_ERR1 : DS_IDLE;
         default: state_d = DS_IDLE;
      endcase
      busy_d   = (state_d != DS_IDLE);
      hready_d = (state_d != DS_ERR1);
      hresp_d  = busy_d ? HRESP_ERROR : HRESP_OKAY;
      tmo_p_d  = tmo;
   end

   // FSM state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= DS_IDLE;
         busy_q   <= 1'b0;
         hready_q <= 1'b1;
         hresp_q  <= HRESP_OKAY;
         tmo_p_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         hready_q <= hready_d;
         hresp_q  <= hresp_d;
         tmo_p_q  <= tmo_p_d;
      end
   end

   assign busy      = busy_q;
   assign hready    = hready_q;
   assign hresp     = hresp_q;
   assign timeout_p = tmo_p_q;

endmodule

// File: rtl/mipsfpga_ahb_interconnect.sv
// AHB-lite single-master interconnect: mask/base decode, data-phase
// select, response mux and default slave. Option: BUS_TIMEOUT_EN.
module mipsfpga_ahb_interconnect
   import mipsfpga_ahb_interconnect_pkg::*;
#(
   parameter int N_SLAVES    = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
   parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = '0,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                       HCLK,
   input  logic                       HRESET,
   input  logic [ADDR_W-1:0]          HADDR,
   input  logic [1:0]                 HTRANS,
   input  logic                       HWRITE,
   input  logic [2:0]                 HSIZE,
   input  logic [DATA_W-1:0]          HWDATA,
   output logic [DATA_W-1:0]          HRDATA,
   output logic                       HREADY,
   output logic                       HRESP,
   output logic [N_SLAVES-1:0]        HSEL_S,
   input  logic [N_SLAVES*DATA_W-1:0] HRDATA_S,
   input  logic [N_SLAVES-1:0]        HREADYOUT_S,
   input  logic [N_SLAVES-1:0]        HRESP_S,
   output logic                       TIMEOUT_P
);

   localparam int NS     = N_SLAVES;
   localparam int DSEL_W = NS + 2;

   localparam logic [DSEL_W-1:0] DSEL_DEF  = DSEL_W'(1) << NS;
   localparam logic [DSEL_W-1:0] DSEL_NONE = DSEL_W'(1) << (NS + 1);

   logic [NS-1:0]     hit;
   logic [NS-1:0]     sel;
   logic              found;
   logic              active;
   logic [DSEL_W-1:0] dsel_q, dsel_d;
   logic              ds_start;
   logic              ds_stall;
   logic              ds_busy;
   logic              ds_hready;
   logic              ds_hresp;
   logic              unused_fwd;

   assign unused_fwd = ^{HWRITE, HSIZE, HWDATA};

   // address decode, lowest index wins on overlap
   always_comb begin
      hit = '0;
      sel = '0;
      for (int i = 0; i < NS; i++)
         hit[i] = ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W])
                   == SLV_BASE[i*ADDR_W +: ADDR_W]);
      for (int i = NS - 1; i >= 0; i--)
         if (hit[i])
            sel = NS'(1) << i;
      found  = |hit;
      active = trans_active(HTRANS);
   end

   assign HSEL_S = active ? sel : '0;

   // data-phase select: loads on accepted address phase
   always_comb begin
      dsel_d = dsel_q;
      if (HREADY) begin
         if (active && found)
            dsel_d = {2'b00, sel};
         else if (active)
            dsel_d = DSEL_DEF;
         else
            dsel_d = DSEL_NONE;
      end
   end

   // data-phase select register
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)
         dsel_q <= DSEL_NONE;
      else
         dsel_q <= dsel_d;
   end

   assign ds_start = HREADY && active && !found;
   assign ds_stall = |(dsel_q[NS-1:0] & ~HREADYOUT_S);

   mipsfpga_ahb_interconnect_default_slave #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_ds (
      .clk       (HCLK),
      .rst       (HRESET),
      .start     (ds_start),
      .stall     (ds_stall),
      .busy      (ds_busy),
      .hready    (ds_hready),
      .hresp     (ds_hresp),
      .timeout_p (TIMEOUT_P)
   );

   // response mux: default slave overrides, else selected slave
   always_comb begin
      HRDATA = '0;
      HREADY = 1'b1;
      HRESP  = HRESP_OKAY;
      for (int i = 0; i < NS; i++) begin
         if (dsel_q[i]) begin
            HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
            HREADY = HREADYOUT_S[i];
            HRESP  = HRESP_S[i];
         end
      end
      if (ds_busy) begin
         HRDATA = '0;
         HREADY = ds_hready;
         HRESP  = ds_hresp;
      end
   end

endmodule

// File: tb/tb_mipsfpga_ahb_interconnect.sv
// Directed bench for mipsfpga_ahb_interconnect (3 slaves, MIPSfpga map).
// Timeout expectations follow BUS_TIMEOUT_EN.
module tb_mipsfpga_ahb_interconnect;

   localparam logic [31:0] D0 = 32'h00C0FFEE;
   localparam logic [31:0] D1 = 32'h11111111;
   localparam logic [31:0] D2 = 32'h22222222;
   localparam logic [1:0]  T_IDLE = 2'b00;
   localparam logic [1:0]  T_NSEQ = 2'b10;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;
   logic [2:0]  HSEL_S;
   logic [95:0] HRDATA_S;
   logic [2:0]  HREADYOUT_S;
   logic [2:0]  HRESP_S;
   logic        TIMEOUT_P;

   int n_checks = 0;
   int n_errors = 0;

   always #5 HCLK = ~HCLK;

   mipsfpga_ahb_interconnect #(
      .N_SLAVES    (3),
      .ADDR_W      (32),
      .DATA_W      (32),
      .SLV_BASE    ({32'h1f800000, 32'h00000000, 32'h1fc00000}),
      .SLV_MASK    ({32'h1f800000, 32'h10000000, 32'h1fc00000}),
      .TIMEOUT_CYC (8)
   ) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HWRITE      (HWRITE),
      .HSIZE       (HSIZE),
      .HWDATA      (HWDATA),
      .HRDATA      (HRDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .HSEL_S      (HSEL_S),
      .HRDATA_S    (HRDATA_S),
      .HREADYOUT_S (HREADYOUT_S),
      .HRESP_S     (HRESP_S),
      .TIMEOUT_P   (TIMEOUT_P)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive(input logic [1:0] t, input logic [31:0] a,
                        input logic w);
      HTRANS = t;
      HADDR  = a;
      HWRITE = w;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESET      = 1'b1;
      HADDR       = 32'h0;
      HTRANS      = T_IDLE;
      HWRITE      = 1'b0;
      HSIZE       = 3'b010;
      HWDATA      = 32'h0;
      HRDATA_S    = {D2, D1, D0};
      HREADYOUT_S = 3'b111;
      HRESP_S     = 3'b000;
      #1;
      check("rst_hready", 32'(HREADY), 32'd1);
      check("rst_hresp", 32'(HRESP), 32'd0);
      check("rst_hrdata", HRDATA, 32'h0);
      check("rst_tmo", 32'(TIMEOUT_P), 32'd0);
      tick();
      tick();
      HRESET = 1'b0;

      // 1: read RAM_RESET, GPIO decode, IDLE never selects
      drive(T_IDLE, 32'h1fc00004, 1'b0);
      #1;
      check("idle_hsel", 32'(HSEL_S), 32'd0);
      drive(T_NSEQ, 32'h1f800000, 1'b0);
      #1;
      check("gpio_hsel", 32'(HSEL_S), 32'b100);
      drive(T_NSEQ, 32'h1fc00004, 1'b0);
      #1;
      check("t1_hsel", 32'(HSEL_S), 32'b001);
      tick();
      drive(T_IDLE, 32'h0, 1'b0);
      #1;
      check("t1_hrdata", HRDATA, D0);
      check("t1_hready", 32'(HREADY), 32'd1);
      check("t1_hresp", 32'(HRESP), 32'd0);

      // 2: write RAM with 3 wait states, next address held
      drive(T_NSEQ, 32'h00000010, 1'b1);
      #1;
      check("t2_hsel", 32'(HSEL_S), 32'b010);
      tick();
      drive(T_NSEQ, 32'h1f800000, 1'b0);
      HWDATA      = 32'hDEADBEEF;
      HREADYOUT_S = 3'b101;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t2_stall", 32'(HREADY), 32'd0);
         check("t2_hwdata", HWDATA, 32'hDEADBEEF);
         tick();
      end
      HREADYOUT_S = 3'b111;
      #1;
      check("t2_done", 32'(HREADY), 32'd1);
      check("t2_held", HRDATA, D1);
      tick();
      drive(T_IDLE, 32'h0, 1'b0);
      #1;
      check("t2_next", HRDATA, D2);
      tick();

      // 3: unmapped pair, back-to-back, then IDLE unmapped
      drive(T_NSEQ, 32'h1e000000, 1'b0);
      #1;
      check("t3_hsel", 32'(HSEL_S), 32'd0);
      tick();
      drive(T_NSEQ, 32'h1e000004, 1'b0);
      #1;
      check("t3_e1_rdy", 32'(HREADY), 32'd0);
      check("t3_e1_rsp", 32'(HRESP), 32'd1);
      check("t3_e1_dat", HRDATA, 32'h0);
      tick();
      #1;
      check("t3_e2_rdy", 32'(HREADY), 32'd1);
      check("t3_e2_rsp", 32'(HRESP), 32'd1);
      tick();
      drive(T_IDLE, 32'h1e000000, 1'b0);
      #1;
      check("t3_b2b_e1_rdy", 32'(HREADY), 32'd0);
      check("t3_b2b_e1_rsp", 32'(HRESP), 32'd1);
      tick();
      #1;
      check("t3_b2b_e2_rdy", 32'(HREADY), 32'd1);
      check("t3_b2b_e2_rsp", 32'(HRESP), 32'd1);
      tick();
      #1;
      check("t3_idle_rdy", 32'(HREADY), 32'd1);
      check("t3_idle_rsp", 32'(HRESP), 32'd0);
      tick();
      #1;
      check("t3_idle2_rsp", 32'(HRESP), 32'd0);

      // 4: reset during ERR1 and during a slave stall
      drive(T_NSEQ, 32'h1e000000, 1'b0);
      tick();
      drive(T_IDLE, 32'h0, 1'b0);
      #1;
      check("t4_in_err1", 32'(HREADY), 32'd0);
      HRESET = 1'b1;
      #1;
      check("t4_e_rdy", 32'(HREADY), 32'd1);
      check("t4_e_rsp", 32'(HRESP), 32'd0);
      tick();
      HRESET = 1'b0;
      drive(T_NSEQ, 32'h1fc00000, 1'b0);
      tick();
      drive(T_IDLE, 32'h0, 1'b0);
      HREADYOUT_S = 3'b110;
      #1;
      check("t4_stall", 32'(HREADY), 32'd0);
      check("t4_stall_dat", HRDATA, D0);
      HRESET = 1'b1;
      #1;
      check("t4_s_rdy", 32'(HREADY), 32'd1);
      check("t4_s_dat", HRDATA, 32'h0);
      check("t4_s_rsp", 32'(HRESP), 32'd0);
      tick();
      HRESET      = 1'b0;
      HREADYOUT_S = 3'b111;
      drive(T_NSEQ, 32'h00000020, 1'b0);
      tick();
      drive(T_IDLE, 32'h0, 1'b0);
      #1;
      check("t4_clean_dat", HRDATA, D1);
      check("t4_clean_rdy", 32'(HREADY), 32'd1);
      tick();

      // 5: GPIO stalls forever
      drive(T_NSEQ, 32'h1f800004, 1'b0);
      tick();
      drive(T_IDLE, 32'h0, 1'b0);
      HREADYOUT_S = 3'b011;
`ifdef BUS_TIMEOUT_EN
      for (int i = 1; i <= 8; i++) begin
         #1;
         check("t5_stall", 32'(HREADY), 32'd0);
         check("t5_no_tmo", 32'(TIMEOUT_P), 32'd0);
         tick();
      end
      #1;
      check("t5_tmo_p", 32'(TIMEOUT_P), 32'd1);
      check("t5_e1_rdy", 32'(HREADY), 32'd0);
      check("t5_e1_rsp", 32'(HRESP), 32'd1);
      tick();
      #1;
      check("t5_tmo_once", 32'(TIMEOUT_P), 32'd0);
      check("t5_e2_rdy", 32'(HREADY), 32'd1);
      check("t5_e2_rsp", 32'(HRESP), 32'd1);
      tick();
      #1;
      check("t5_ok_rdy", 32'(HREADY), 32'd1);
      check("t5_ok_rsp", 32'(HRESP), 32'd0);
      HREADYOUT_S = 3'b111;
      drive(T_NSEQ, 32'h00000000, 1'b0);
      tick();
      drive(T_IDLE, 32'h0, 1'b0);
      #1;
      check("t5_resume", HRDATA, D1);
`else
      for (int i = 0; i < 100; i++) begin
         #1;
         if (i % 10 == 0) begin
            check("t5_stall", 32'(HREADY), 32'd0);
            check("t5_no_tmo", 32'(TIMEOUT_P), 32'd0);
         end
         tick();
      end
      #1;
      check("t5_still", 32'(HREADY), 32'd0);
      HREADYOUT_S = 3'b111;
      #1;
      check("t5_release", 32'(HREADY), 32'd1);
      check("t5_rel_dat", HRDATA, D2);
`endif
      tick();
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
